// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the frame-buffer scheduler and its neighbours.
package vga_pkg;

    // Display geometry (640x480 @ 60 Hz, pixel-clock domain)
    localparam int NUM_ROWS  = 480;
    localparam int NUM_COLS  = 640;

    // Horizontal timing, in pixel clocks
    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = HS_START + H_SYNC;

    // Vertical timing, in lines
    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = VS_START + V_SYNC;

    // Frame-buffer word address and pixel widths
    localparam int FB_ADDR_W = 19;
    localparam int PIXEL_W   = 8;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [PIXEL_W-1:0]   pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/vga_fb_scheduler_if.sv
// Bus bundles around the scheduler: camera write channel and frame-buffer SRAM port.

// Camera write request channel: the camera is master, the scheduler is slave.
interface fb_cam_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              cam_valid;
    logic              cam_ready;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;

    modport master (output cam_valid, output cam_addr, output cam_data, input cam_ready);
    modport slave  (input cam_valid, input cam_addr, input cam_data, output cam_ready);
endinterface

// Single-port frame-buffer SRAM: the scheduler is master, the memory is slave.
interface fb_mem_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_we, output mem_addr, output mem_wdata,
                    input mem_rvalid, input mem_rdata);
    modport slave  (input mem_req, input mem_we, input mem_addr, input mem_wdata,
                    output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/fb_arbiter.sv
// Two-requester arbiter for the single frame-buffer port. Prefetch reads win,
// but a waiting camera is forced through once every CAM_SLOT cycles.
module fb_arbiter
    import vga_pkg::*;
#(
    parameter int CAM_SLOT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cam_valid_i,
    input  logic rd_req_i,
    output logic cam_gnt_o,
    output logic rd_gnt_o
);

    localparam int                  STARVE_W   = (CAM_SLOT > 2) ? $clog2(CAM_SLOT) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(CAM_SLOT - 1);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    // Grant decision: camera gets the slot when no read competes or it has waited long enough.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        cam_gnt_o = 1'b0;
        rd_gnt_o  = 1'b0;
        if (cam_valid_i && (!rd_req_i || starve_q == STARVE_MAX)) begin
            cam_gnt_o = 1'b1;
        end else if (rd_req_i) begin
            rd_gnt_o = 1'b1;
        end
    end

    // Starvation count: cycles the camera has been held off while still requesting.
    always_comb begin
        starve_d = '0;
        if (cam_valid_i && !cam_gnt_o) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Starvation register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Frame-buffer scheduler: prefetches one display row into a ping-pong line
// buffer per line_req while sharing the SRAM port with the camera writer.
module vga_fb_scheduler
    import vga_pkg::*;
#(
    parameter int ADDR_W   = vga_pkg::FB_ADDR_W,
    parameter int DATA_W   = vga_pkg::PIXEL_W,
    parameter int NUM_COLS = vga_pkg::NUM_COLS,
    parameter int MEM_LAT  = 2,
    parameter int CAM_SLOT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_req,
    input  logic [9:0]        line_num,
    fb_cam_if.slave           cam,
    fb_mem_if.master          mem,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [9:0]        lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              fetch_busy,
    output logic              underrun
);

    localparam logic [9:0] COLS = 10'(NUM_COLS);

    // Returns still in flight when reset hits arrive within MEM_LAT cycles;
    // a short flush window keeps them out of a fetch started right after reset.
    localparam int                  FLUSH_W    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [FLUSH_W-1:0]  FLUSH_INIT = FLUSH_W'(MEM_LAT);

    sched_state_t        state_q, state_d;
    logic [9:0]          issue_cnt_q, issue_cnt_d;
    logic [9:0]          ret_cnt_q, ret_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                lb_bank_q, lb_bank_d;
    logic                underrun_q, underrun_d;
    logic [FLUSH_W-1:0]  flush_q, flush_d;

    logic                line_accept;
    logic                cam_req;
    logic                rd_req;
    logic                cam_gnt;
    logic                rd_gnt;
    logic                ret_take;

    // Camera requests and read requests are masked while reset is held so the port stays quiet.
    assign cam_req     = cam.cam_valid & ~rst;
    assign line_accept = line_req & (state_q == IDLE);
    assign ret_take    = mem.mem_rvalid & ~rst & (state_q != IDLE)
                       & (flush_q == '0) & (ret_cnt_q < COLS);

    fb_arbiter #(
        .CAM_SLOT (CAM_SLOT)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .cam_valid_i (cam_req),
        .rd_req_i    (rd_req),
        .cam_gnt_o   (cam_gnt),
        .rd_gnt_o    (rd_gnt)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave FETCH on the last issue and DRAIN on the last return.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (line_accept)         state_d = FETCH;
            FETCH:   if (issue_cnt_d == COLS) state_d = DRAIN;
            DRAIN:   if (ret_cnt_d == COLS)   state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the read request presented to the arbiter.
    always_comb begin
        fetch_busy = (state_q != IDLE);
        rd_req     = (state_q == FETCH) && (issue_cnt_q < COLS) && !rst;
    end

    // Datapath next state: row base, issue/return counters, bank, error flag, flush window.
    always_comb begin
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        lb_bank_d   = lb_bank_q;
        underrun_d  = underrun_q | (line_req & (state_q != IDLE));
        flush_d     = (flush_q != '0) ? flush_q - FLUSH_W'(1) : flush_q;

        if (line_accept) begin
            base_d      = ADDR_W'(32'(line_num) * 32'(NUM_COLS));
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            lb_bank_d   = ~lb_bank_q;
        end
        if (rd_gnt) begin
            issue_cnt_d = issue_cnt_q + 10'd1;
        end
        if (ret_take) begin
            ret_cnt_d = ret_cnt_q + 10'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            lb_bank_q   <= 1'b0;
            underrun_q  <= 1'b0;
            flush_q     <= FLUSH_INIT;
        end else begin
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            lb_bank_q   <= lb_bank_d;
            underrun_q  <= underrun_d;
            flush_q     <= flush_d;
        end
    end

    // Memory port mux: camera write or prefetch read, same-cycle with the grant.
    always_comb begin
        cam.cam_ready = cam_gnt;
        mem.mem_req   = cam_gnt | rd_gnt;
        mem.mem_we    = cam_gnt;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (cam_gnt) begin
            mem.mem_addr  = cam.cam_addr;
            mem.mem_wdata = cam.cam_data;
        end else if (rd_gnt) begin
            mem.mem_addr  = base_q + ADDR_W'(issue_cnt_q);
        end
    end

    // Line-buffer write port: read returns pass straight through into the current bank.
    always_comb begin
        lb_we    = ret_take;
        lb_addr  = ret_take ? ret_cnt_q : '0;
        lb_data  = ret_take ? mem.mem_rdata : '0;
        lb_bank  = lb_bank_q;
        underrun = underrun_q;
    end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a fixed-latency SRAM model.
module tb_vga_fb_scheduler;
    import vga_pkg::*;

    localparam int AW   = 19;
    localparam int DW   = 8;
    localparam int COLS = 640;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              line_req = 1'b0;
    logic [9:0]        line_num = '0;
    logic              lb_we;
    logic              lb_bank;
    logic [9:0]        lb_addr;
    logic [DW-1:0]     lb_data;
    logic              fetch_busy;
    logic              underrun;

    fb_cam_if #(.ADDR_W(AW), .DATA_W(DW)) cam_bus ();
    fb_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    vga_fb_scheduler #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_COLS (COLS),
        .MEM_LAT  (2),
        .CAM_SLOT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_req   (line_req),
        .line_num   (line_num),
        .cam        (cam_bus),
        .mem        (mem_bus),
        .lb_we      (lb_we),
        .lb_bank    (lb_bank),
        .lb_addr    (lb_addr),
        .lb_data    (lb_data),
        .fetch_busy (fetch_busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // SRAM model: two-cycle read latency, read data = low byte of the address.
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [AW-1:0] p1_a = '0,   p2_a = '0;
    always @(posedge clk) begin
        p1_v <= mem_bus.mem_req && !mem_bus.mem_we;
        p1_a <= mem_bus.mem_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign mem_bus.mem_rvalid = p2_v;
    assign mem_bus.mem_rdata  = p2_a[DW-1:0];

    int checks = 0;
    int errors = 0;

    // Monitor statistics
    int            cyc;
    int            rd_cnt, lb_cnt, gnt_cnt, wr_cnt, mid_gnt;
    int            gap_err, wr_err, seq_err, lb_err, bank_err, stall_cnt, run;
    int            first_rd, last_rd, first_rd_cyc, last_rd_cyc, fall_cyc;
    logic          busy_prev;
    logic [AW-1:0] exp_rd_addr, exp_base;
    logic          exp_bank;
    logic [9:0]    exp_lb_addr;
    int            cam_seq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; lb_cnt = 0; gnt_cnt = 0; wr_cnt = 0; mid_gnt = 0;
        gap_err = 0; wr_err = 0; seq_err = 0; lb_err = 0; bank_err = 0;
        stall_cnt = 0; run = 0;
        first_rd = -1; last_rd = -1; first_rd_cyc = 0; last_rd_cyc = 0; fall_cyc = 0;
        exp_rd_addr = exp_base;
        exp_lb_addr = '0;
    endtask

    task automatic sample();
        if (mem_bus.mem_req && !mem_bus.mem_we) begin
            if (rd_cnt == 0) begin
                first_rd     = int'(mem_bus.mem_addr);
                first_rd_cyc = cyc;
            end
            if (mem_bus.mem_addr != exp_rd_addr) seq_err++;
            exp_rd_addr = exp_rd_addr + 1'b1;
            last_rd     = int'(mem_bus.mem_addr);
            last_rd_cyc = cyc;
            rd_cnt++;
            run++;
        end
        if (cam_bus.cam_ready) begin
            if (fetch_busy && rd_cnt > 0 && rd_cnt < COLS) begin
                mid_gnt++;
                if (run != 3) gap_err++;
            end
            run = 0;
            gnt_cnt++;
            if (!(mem_bus.mem_req && mem_bus.mem_we && mem_bus.mem_addr == cam_bus.cam_addr
                  && mem_bus.mem_wdata == cam_bus.cam_data)) wr_err++;
        end
        if (cam_bus.cam_valid && !cam_bus.cam_ready) stall_cnt++;
        if (mem_bus.mem_req && mem_bus.mem_we) wr_cnt++;
        if (lb_we) begin
            if (lb_addr != exp_lb_addr || lb_data != DW'(exp_base + AW'(exp_lb_addr))) lb_err++;
            if (lb_bank != exp_bank) bank_err++;
            exp_lb_addr = exp_lb_addr + 10'd1;
            lb_cnt++;
        end
        if (busy_prev && !fetch_busy) fall_cyc = cyc;
        busy_prev = fetch_busy;
    endtask

    task automatic start_line(input logic [9:0] n, input logic [AW-1:0] base, input logic bank);
        @(posedge clk); #1;
        line_req = 1'b1;
        line_num = n;
        exp_base = base;
        exp_bank = bank;
        clear_stats();
        @(posedge clk); #1;
        line_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (fetch_busy && n < budget);
        check({tag, "_idle"}, fetch_busy, 0);
    endtask

    task automatic wait_reads(input string tag, input int target, input int budget);
        int n = 0;
        while (rd_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_reads"}, rd_cnt, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc = 0; cam_seq = 0; busy_prev = 1'b0;
        exp_base = '0; exp_bank = 1'b0;
        cam_bus.cam_valid = 1'b0;
        clear_stats();

        fork
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                cam_seq++;
                cam_bus.cam_addr = AW'(cam_seq * 7 + 100);
                cam_bus.cam_data = DW'(cam_seq * 3 + 1);
            end
            forever begin
                @(negedge clk);
                sample();
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_outs",
              {mem_bus.mem_req, mem_bus.mem_we, cam_bus.cam_ready, lb_we, lb_bank,
               fetch_busy, underrun, |mem_bus.mem_addr, |lb_addr, |lb_data}, 0);
        repeat (3) @(posedge clk);

        // Row 2, no camera traffic
        start_line(10'd2, 19'd1280, 1'b1);
        wait_idle("row2", 2000);
        check("row2_rd_cnt",   rd_cnt, 640);
        check("row2_first",    first_rd, 1280);
        check("row2_last",     last_rd, 1919);
        check("row2_seq_err",  seq_err, 0);
        check("row2_lb_cnt",   lb_cnt, 640);
        check("row2_lb_err",   lb_err, 0);
        check("row2_bank_err", bank_err, 0);
        check("row2_bank",     lb_bank, 1);
        check("row2_busy_lag", fall_cyc - last_rd_cyc, 3);

        // Row 0 with the camera requesting every cycle
        @(posedge clk); #1 cam_bus.cam_valid = 1'b1;
        repeat (2) @(posedge clk);
        start_line(10'd0, 19'd0, 1'b0);
        wait_idle("row0", 2000);
        @(posedge clk); #1 cam_bus.cam_valid = 1'b0;
        check("row0_rd_cnt",   rd_cnt, 640);
        check("row0_span",     last_rd_cyc - first_rd_cyc + 1, 853);
        check("row0_mid_gnt",  mid_gnt, 213);
        check("row0_gap_err",  gap_err, 0);
        check("row0_wr_err",   wr_err, 0);
        check("row0_lb_cnt",   lb_cnt, 640);
        check("row0_lb_err",   lb_err, 0);
        check("row0_bank_err", bank_err, 0);

        // Camera-only burst in IDLE
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        clear_stats();
        cam_bus.cam_valid = 1'b1;
        repeat (100) @(posedge clk);
        #1 cam_bus.cam_valid = 1'b0;
        @(negedge clk); #1;
        check("cam_gnt_cnt", gnt_cnt, 100);
        check("cam_wr_cnt",  wr_cnt, 100);
        check("cam_stall",   stall_cnt, 0);
        check("cam_rd_cnt",  rd_cnt, 0);
        check("cam_wr_err",  wr_err, 0);
        check("cam_underrun", underrun, 0);

        // Second line_req while draining
        start_line(10'd5, 19'd3200, 1'b1);
        wait_reads("drain", 640, 2000);
        @(posedge clk); #1 line_req = 1'b1; line_num = 10'd6;
        @(posedge clk); #1 line_req = 1'b0;
        @(negedge clk); #1;
        check("drain_underrun", underrun, 1);
        wait_idle("drain", 200);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        check("drain_busy",     fetch_busy, 0);
        check("drain_rd_cnt",   rd_cnt, 640);
        check("drain_lb_cnt",   lb_cnt, 640);
        check("drain_lb_err",   lb_err, 0);
        check("drain_bank_err", bank_err, 0);
        check("drain_bank",     lb_bank, 1);
        check("drain_sticky",   underrun, 1);

        // Reset in the middle of a fetch
        start_line(10'd7, 19'd4480, 1'b0);
        wait_reads("mid", 300, 2000);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_base = '0;
        clear_stats();
        @(negedge clk); #1;
        check("mid_rst_outs",
              {mem_bus.mem_req, mem_bus.mem_we, cam_bus.cam_ready, lb_we, lb_bank,
               fetch_busy, underrun, |mem_bus.mem_addr, |lb_addr, |lb_data}, 0);
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("mid_late_lb", lb_cnt, 0);
        start_line(10'd1, 19'd640, 1'b1);
        wait_idle("after_rst", 2000);
        check("after_rst_rd_cnt",   rd_cnt, 640);
        check("after_rst_lb_cnt",   lb_cnt, 640);
        check("after_rst_lb_err",   lb_err, 0);
        check("after_rst_bank_err", bank_err, 0);
        check("after_rst_bank",     lb_bank, 1);

        // Last row: no address wrap
        start_line(10'd479, 19'd306560, 1'b0);
        wait_idle("row479", 2000);
        check("row479_first",   first_rd, 306560);
        check("row479_last",    last_rd, 307199);
        check("row479_seq_err", seq_err, 0);
        check("row479_lb_cnt",  lb_cnt, 640);
        check("row479_lb_err",  lb_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
